fence_ctrl: RTL

Sequencer for fence-class instructions retiring on commit port 0: FENCE, FENCE.I, SFENCE.VMA and the external D$ flush request. It waits for the store buffer to drain, then runs the D$ write-back, I$ invalidate and TLB flush steps in a fixed order. On completion it issues a single commit acknowledge and a pipeline flush. It sits between the commit stage and the controller, which owns the cache and TLB flush datapaths.

---
 rtl/ariane_pkg.sv | 25 ++
 rtl/sat_counter.sv | 19 +
 rtl/fence_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared types for the fence sequencer: fence operation codes and FSM states.
package ariane_pkg;

  typedef enum logic [1:0] {
    FENCE        = 2'd0,
    FENCE_I      = 2'd1,
    SFENCE_VMA   = 2'd2,
    DCACHE_FLUSH = 2'd3
  } fence_op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    DFLUSH   = 3'd2,
    IFLUSH   = 3'd3,
    TLBFLUSH = 3'd4,
    DONE     = 3'd5
  } fence_ctrl_state_e;

  // Ops whose D$ write-back must be followed by an I$ invalidate.
  function automatic logic op_needs_iflush(fence_op_e op);
    return (op == FENCE_I) || (op == DCACHE_FLUSH);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (en_i && (count_o != {Width{1'b1}})) begin
      count_o <= count_o + Width'(1);
    end
  end

endmodule

// File: rtl/fence_ctrl.sv
// Fence-class instruction sequencer: drain stores, then D$ write-back, I$ invalidate, TLB flush.
// Optional busy-cycle counter enabled by defining FENCE_CTRL_PERF_EN.
module fence_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  logic [1:0]          req_op_i,
  output logic                req_ready_o,
  input  logic                halt_i,
  input  logic                no_st_pending_i,
  output logic                dcache_flush_o,
  input  logic                dcache_flush_ack_i,
  output logic                icache_flush_o,
  output logic                tlb_flush_o,
  output logic                flush_pipeline_o,
  output logic                busy_o,
  output logic [CntWidth-1:0] busy_cycles_o
);

  fence_ctrl_state_e state_q, state_d;
  fence_op_e         op_q;
  logic              accept;

  assign accept = req_valid_i && !halt_i;

  // State and latched operation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= FENCE;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && accept) begin
        op_q <= fence_op_e'(req_op_i);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = DRAIN;
      end
      DRAIN: begin
        // A withdrawn request is dropped before any side effect.
        if (!req_valid_i) begin
          state_d = IDLE;
        end else if (no_st_pending_i) begin
          state_d = (op_q == SFENCE_VMA) ? TLBFLUSH : DFLUSH;
        end
      end
      DFLUSH: begin
        if (dcache_flush_ack_i) begin
          state_d = op_needs_iflush(op_q) ? IFLUSH : DONE;
        end
      end
      IFLUSH:   state_d = DONE;
      TLBFLUSH: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    req_ready_o      = 1'b0;
    dcache_flush_o   = 1'b0;
    icache_flush_o   = 1'b0;
    tlb_flush_o      = 1'b0;
    flush_pipeline_o = 1'b0;
    busy_o           = (state_q != IDLE);
    unique case (state_q)
      DFLUSH:   dcache_flush_o = 1'b1;
      IFLUSH:   icache_flush_o = 1'b1;
      TLBFLUSH: tlb_flush_o    = 1'b1;
      DONE: begin
        req_ready_o      = 1'b1;
        flush_pipeline_o = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FENCE_CTRL_PERF_EN
  sat_counter #(
    .Width(CntWidth)
  ) u_busy_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (busy_o),
    .count_o(busy_cycles_o)
  );
`else
  assign busy_cycles_o = '0;
`endif

endmodule
